// File: rtl/sprite_pkg.sv
// Shared types, FSM encoding and reset origins for the sprite scheduler.
// Compile this file first; the other files import sprite_pkg::*.
package sprite_pkg;

   localparam int unsigned POS_W   = 10;
   localparam int          ORIG_DX = 64;
   localparam int          ORIG_DY = 32;

   typedef logic [POS_W-1:0] pos_t;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic DIR_UP    = 1'b1;

   typedef struct packed {
      pos_t x;
      pos_t y;
      logic dir_x;
      logic dir_y;
   } sprite_state_t;

   typedef enum logic {
      ST_IDLE,
      ST_UPD
   } sched_state_t;

   // Sprites start on a diagonal staircase; odd sprites head left so neighbours converge.
   function automatic sprite_state_t reset_sprite(input int idx, input int pad);
      sprite_state_t s;
      s.x     = pos_t'(pad + ORIG_DX * idx);
      s.y     = pos_t'(pad + ORIG_DY * idx);
      s.dir_x = (idx % 2 == 1) ? DIR_LEFT : DIR_RIGHT;
      s.dir_y = DIR_DOWN;
      return s;
   endfunction

endpackage

// File: rtl/sprite_scheduler_if.sv
// Pixel-side bus of the sprite scheduler: raster position and enables in,
// per-pixel hit result, update-busy and collision flag out.
interface sprite_scheduler_if
   import sprite_pkg::*;
#(
   parameter int unsigned NUM_SPR = 4
);

   pos_t               pix_x;
   pos_t               pix_y;
   logic [NUM_SPR-1:0] spr_en;
   logic               busy;
   logic               hit;
   logic [1:0]         hit_id;
   logic [5:0]         loc_x;
   logic [3:0]         loc_y;
   logic               collide;

   modport master (
      output pix_x, pix_y, spr_en,
      input  busy, hit, hit_id, loc_x, loc_y, collide
   );

   modport slave (
      input  pix_x, pix_y, spr_en,
      output busy, hit, hit_id, loc_x, loc_y, collide
   );

endinterface

// File: rtl/sprite_bounce_step.sv
// Combinational one-frame motion step for a single sprite: move one pixel per
// axis, reversing direction when the sprite reaches the padded screen edge.
module sprite_bounce_step
   import sprite_pkg::*;
#(
   parameter int unsigned SPR_W = 37,
   parameter int unsigned SPR_H = 12,
   parameter int unsigned PAD   = 32,
   parameter int unsigned X_MAX = 640,
   parameter int unsigned Y_MAX = 480
) (
   input  sprite_state_t i_cur,
   output sprite_state_t o_next
);

   localparam pos_t ONE   = pos_t'(1);
   localparam pos_t W_W   = pos_t'(SPR_W);
   localparam pos_t W_H   = pos_t'(SPR_H);
   localparam pos_t PAD_P = pos_t'(PAD);
   localparam pos_t LIM_X = pos_t'(X_MAX - PAD);
   localparam pos_t LIM_Y = pos_t'(Y_MAX - PAD);

   always_comb begin
      // NOTE: start from "hold" so every path assigns o_next and no latch is inferred.
      o_next = i_cur;

      if (i_cur.dir_x == DIR_RIGHT) begin
         if (i_cur.x + W_W >= LIM_X) begin
            o_next.dir_x = DIR_LEFT;
            o_next.x     = i_cur.x - ONE;
         end else begin
            o_next.x     = i_cur.x + ONE;
         end
      end else begin
         if (i_cur.x <= PAD_P) begin
            o_next.dir_x = DIR_RIGHT;
            o_next.x     = i_cur.x + ONE;
         end else begin
            o_next.x     = i_cur.x - ONE;
         end
      end

      if (i_cur.dir_y == DIR_DOWN) begin
         if (i_cur.y + W_H >= LIM_Y) begin
            o_next.dir_y = DIR_UP;
            o_next.y     = i_cur.y - ONE;
         end else begin
            o_next.y     = i_cur.y + ONE;
         end
      end else begin
         if (i_cur.y <= PAD_P) begin
            o_next.dir_y = DIR_DOWN;
            o_next.y     = i_cur.y + ONE;
         end else begin
            o_next.y     = i_cur.y - ONE;
         end
      end
   end

endmodule

// File: rtl/sprite_scheduler.sv
// Bouncing-sprite scheduler: per-frame position update FSM plus registered
// per-pixel hit lookup. Optional collision flag built under `SPRITE_COLLIDE_EN.
module sprite_scheduler
   import sprite_pkg::*;
#(
   parameter int unsigned NUM_SPR = 4,
   parameter int unsigned SPR_W   = 37,
   parameter int unsigned SPR_H   = 12,
   parameter int unsigned PAD     = 32,
   parameter int unsigned X_MAX   = 640,
   parameter int unsigned Y_MAX   = 480
) (
   input  logic              clk,
   input  logic              rst_n,
   sprite_scheduler_if.slave bus
);

   localparam logic [1:0] LAST_IDX = 2'(NUM_SPR - 1);
   localparam pos_t       W_W      = pos_t'(SPR_W);
   localparam pos_t       W_H      = pos_t'(SPR_H);

   sched_state_t       r_state;
   sched_state_t       w_state_nxt;
   logic [1:0]         r_idx;
   logic [1:0]         w_idx_nxt;
   logic               r_prev_zero;
   logic               w_at_origin;
   logic               w_frame_go;

   sprite_state_t      r_spr [NUM_SPR];
   sprite_state_t      w_cur;
   sprite_state_t      w_next;
   logic [NUM_SPR-1:0] w_cover;

   logic               w_hit;
   logic               r_hit;
   logic [1:0]         w_hit_id;
   logic [1:0]         r_hit_id;
   logic [5:0]         w_loc_x;
   logic [5:0]         r_loc_x;
   logic [3:0]         w_loc_y;
   logic [3:0]         r_loc_y;

   // Only the first (0,0) cycle starts a frame, and only while no update is running.
   assign w_at_origin = (bus.pix_x == '0) && (bus.pix_y == '0);
   assign w_frame_go  = w_at_origin && !r_prev_zero && (r_state == ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_prev_zero <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values regardless of order.
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_prev_zero <= w_at_origin;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      case (r_state)
         ST_IDLE: begin
            if (w_frame_go) begin
               w_state_nxt = ST_UPD;
               w_idx_nxt   = '0;
            end
         end
         ST_UPD: begin
            if (r_idx == LAST_IDX) begin
               w_state_nxt = ST_IDLE;
               w_idx_nxt   = '0;
            end else begin
               w_idx_nxt   = r_idx + 2'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
         end
      endcase
   end

   // A single step unit is shared; the FSM visits one sprite per cycle.
   assign w_cur = r_spr[r_idx];

   sprite_bounce_step #(
      .SPR_W (SPR_W),
      .SPR_H (SPR_H),
      .PAD   (PAD),
      .X_MAX (X_MAX),
      .Y_MAX (Y_MAX)
   ) u_step (
      .i_cur  (w_cur),
      .o_next (w_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the sprite table is a few flops, not a RAM, so it is reset like any other state.
         for (int i = 0; i < int'(NUM_SPR); i++) begin
            r_spr[i] <= reset_sprite(i, int'(PAD));
         end
      end else if ((r_state == ST_UPD) && bus.spr_en[r_idx]) begin
         r_spr[r_idx] <= w_next;
      end
   end

   always_comb begin
      w_cover = '0;
      for (int i = 0; i < int'(NUM_SPR); i++) begin
         w_cover[i] = bus.spr_en[i]
                    && (bus.pix_x >= r_spr[i].x) && (bus.pix_x < r_spr[i].x + W_W)
                    && (bus.pix_y >= r_spr[i].y) && (bus.pix_y < r_spr[i].y + W_H);
      end
   end

   always_comb begin
      w_hit    = 1'b0;
      w_hit_id = '0;
      w_loc_x  = '0;
      w_loc_y  = '0;
      // Descending scan: the lowest covering index is written last and wins.
      for (int i = int'(NUM_SPR) - 1; i >= 0; i--) begin
         if (w_cover[i]) begin
            w_hit    = 1'b1;
            w_hit_id = 2'(i);
            w_loc_x  = 6'(bus.pix_x - r_spr[i].x);
            w_loc_y  = 4'(bus.pix_y - r_spr[i].y);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hit    <= 1'b0;
         r_hit_id <= '0;
         r_loc_x  <= '0;
         r_loc_y  <= '0;
      end else begin
         r_hit    <= w_hit;
         r_hit_id <= w_hit_id;
         r_loc_x  <= w_loc_x;
         r_loc_y  <= w_loc_y;
      end
   end

   assign bus.busy   = (r_state == ST_UPD);
   assign bus.hit    = r_hit;
   assign bus.hit_id = r_hit_id;
   assign bus.loc_x  = r_loc_x;
   assign bus.loc_y  = r_loc_y;

`ifdef SPRITE_COLLIDE_EN
   logic r_sticky;
   logic r_collide;
   logic w_multi;

   assign w_multi = ($countones(w_cover) >= 2);

   // Overlaps accumulate during a frame and are published at the next frame start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky  <= 1'b0;
         r_collide <= 1'b0;
      end else if (w_frame_go) begin
         r_collide <= r_sticky;
         r_sticky  <= 1'b0;
      end else if (w_multi) begin
         r_sticky  <= 1'b1;
      end
   end

   assign bus.collide = r_collide;
`else
   assign bus.collide = 1'b0;
`endif

endmodule
